// File: rtl/pico_pkg.sv
// Shared types for the pico instruction sequencer: opcodes, FSM states, default address width.
// No logic; imported by instr_seq and instr_seq_perf.
// No flow control.
package pico_pkg;

  localparam int unsigned ADDR_SZ_DEF = 6;

  typedef enum logic [2:0] {
    NOP  = 3'd0,
    ADD  = 3'd1,
    ADDI = 3'd2,
    MULI = 3'd3,
    BEQ  = 3'd4,
    BNE  = 3'd5,
    WAIT = 3'd6,
    HLT  = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    START   = 3'd0,
    EXEC    = 3'd1,
    CMP     = 3'd2,
    BRANCH  = 3'd3,
    WAIT_IN = 3'd4,
    STOP    = 3'd5
  } seq_state_t;

endpackage

// File: rtl/instr_seq_perf.sv
// Retired-instruction counter, 16-bit, wraps at 0xFFFF.
// Latency: count visible the cycle after the retire pulse.
// Backpressure: none; the caller gates inc (no increment under debug freeze).
module instr_seq_perf (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        inc,
  output logic [15:0] retired
);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      retired <= '0;
    end else if (inc) begin
      retired <= retired + 16'd1;
    end
  end

endmodule

// File: rtl/instr_seq.sv
// Instruction sequencer FSM driving PC hold/branch and register-file write control.
// Latency: Mealy outputs, combinational from state/inputs; branch = 3 cycles, WAIT >= 2 cycles.
// Backpressure: holds PC while waiting for sw_valid or under dbg_halt; optional INSTR_SEQ_PERF_EN adds retired.
module instr_seq
  import pico_pkg::*;
#(
  parameter int unsigned AddrSz = ADDR_SZ_DEF
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [2:0]        opcode,
  input  logic [AddrSz-1:0] imm,
  input  logic              z,
  input  logic              sw_valid,
  input  logic              dbg_halt,
  output logic              rel_branch,
  output logic [AddrSz-1:0] offset,
  output logic              halt,
  output logic              reg_we,
  output logic              in_sel,
`ifdef INSTR_SEQ_PERF_EN
  output logic [15:0]       retired,
`endif
  output logic              in_ack
);

  seq_state_t state, state_nxt;
  opcode_t    op;
  logic       z_q;

  assign op = opcode_t'(opcode);

  // State and captured zero flag both freeze while the debugger holds the core.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= START;
      z_q   <= 1'b0;
    end else if (!dbg_halt) begin
      state <= state_nxt;
      if (state == CMP) begin
        z_q <= z;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    halt       = 1'b1;
    reg_we     = 1'b0;
    in_sel     = 1'b0;
    in_ack     = 1'b0;
    rel_branch = 1'b0;
    offset     = '0;

    unique case (state)
      START: state_nxt = EXEC;

      EXEC: begin
        unique case (op)
          NOP: halt = 1'b0;
          ADD, ADDI, MULI: begin
            halt   = 1'b0;
            reg_we = 1'b1;
          end
          BEQ, BNE: state_nxt = CMP;
          WAIT:     state_nxt = WAIT_IN;
          HLT:      state_nxt = STOP;
          default:  state_nxt = EXEC;
        endcase
      end

      CMP: state_nxt = BRANCH;

      // PC is held through CMP, so opcode still names the branch being resolved.
      BRANCH: begin
        halt      = 1'b0;
        offset    = imm;
        state_nxt = EXEC;
        if (op == BEQ) begin
          rel_branch = z_q;
        end else if (op == BNE) begin
          rel_branch = ~z_q;
        end
      end

      WAIT_IN: begin
        if (sw_valid) begin
          halt      = 1'b0;
          reg_we    = 1'b1;
          in_sel    = 1'b1;
          in_ack    = 1'b1;
          state_nxt = EXEC;
        end
      end

      STOP: state_nxt = STOP;

      default: state_nxt = START;
    endcase

    if (dbg_halt) begin
      halt       = 1'b1;
      reg_we     = 1'b0;
      in_sel     = 1'b0;
      in_ack     = 1'b0;
      rel_branch = 1'b0;
    end
  end

`ifdef INSTR_SEQ_PERF_EN
  // The PC moves exactly when an instruction completes, so ~halt is the retire strobe.
  instr_seq_perf u_perf (
    .clk     (clk),
    .n_reset (n_reset),
    .inc     (~halt),
    .retired (retired)
  );
`endif

endmodule
